// File: rtl/controlador_alu.sv
// controlador_alu
//    Sequencer in front of the ALU result multiplexor (11 operations, 4-bit
//    select code). Takes one request at a time over inicio/listo, registers
//    the operands for the functional units, runs an iterative restoring
//    unsigned divider for div/mod, drives seleccion for one cycle, captures
//    salidaMux and holds it in resultado until aceptado.
//
// Optional feature macro: BANDERAS_EN
//    defined   : cero/negativo are registered with resultado.
//    undefined : cero/negativo are tied low.
//
// Ports
//    clk, rst_n             clock (rising edge), asynchronous active-low reset
//    inicio / listo         request valid / ready; transfer on inicio & listo
//    operacion              op code (0000..1010 valid, 1011..1111 flagged)
//    operandoA, operandoB   request operands (dividend, divisor)
//    datoA, datoB           registered operands to the functional units
//    cociente, residuo      divider results to the mux div/mod inputs
//    seleccion              mux select code (1111 when not executing)
//    salidaMux              mux output
//    resultado / valido     captured result, held until aceptado
//    aceptado               consumer takes resultado
//    error_div, error_op    division by zero / illegal op code on last request
//    cero, negativo         result flags
module controlador_alu #(
   parameter int ancho = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inicio,
   output logic             listo,
   input  logic [3:0]       operacion,
   input  logic [ancho-1:0] operandoA,
   input  logic [ancho-1:0] operandoB,
   output logic [ancho-1:0] datoA,
   output logic [ancho-1:0] datoB,
   output logic [ancho-1:0] cociente,
   output logic [ancho-1:0] residuo,
   output logic [3:0]       seleccion,
   input  logic [ancho-1:0] salidaMux,
   output logic [ancho-1:0] resultado,
   output logic             valido,
   input  logic             aceptado,
   output logic             error_div,
   output logic             error_op,
   output logic             cero,
   output logic             negativo
);

   localparam int anchoCnt = (ancho > 1) ? $clog2(ancho) : 1;

   typedef enum logic [1:0] {
      REPOSO,
      DIVIDE,
      EJECUTA,
      ENTREGA
   } estado_t;

   estado_t estadoReg, estadoNext;

   logic [3:0]          opReg;
   logic [anchoCnt-1:0] contadorReg;
   // Working registers of the divider: partial remainder and a shift
   // register that starts as the dividend and fills up with quotient bits.
   logic [ancho-1:0]    restoReg;
   logic [ancho-1:0]    cocienteParcialReg;

   logic esDivision;
   logic divisorCero;

   assign esDivision  = (operacion == 4'b0011) || (operacion == 4'b0100);
   assign divisorCero = (operandoB == '0);

   // ---------------------------------------------------------------
   // One restoring-division step. The shifted remainder needs one extra
   // bit; when the trial subtraction goes negative the remainder is kept,
   // and in that case it is known to fit in ancho bits (it is < divisor).
   // ---------------------------------------------------------------
   logic [ancho:0]   restoDesplazado;
   logic [ancho:0]   restoResta;
   logic [ancho-1:0] restoNext;
   logic [ancho-1:0] cocienteNext;
   logic             bitCociente;

   always_comb begin
      restoDesplazado = {restoReg, cocienteParcialReg[ancho-1]};
      restoResta      = restoDesplazado - {1'b0, datoB};
      bitCociente     = ~restoResta[ancho];
      restoNext       = bitCociente ? restoResta[ancho-1:0] : restoDesplazado[ancho-1:0];
      cocienteNext    = {cocienteParcialReg[ancho-2:0], bitCociente};
   end

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estadoReg <= REPOSO;
      end else begin
         estadoReg <= estadoNext;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state and handshake/select outputs
   // ---------------------------------------------------------------
   always_comb begin
      estadoNext = estadoReg;
      listo      = 1'b0;
      seleccion  = 4'b1111;
      case (estadoReg)
         REPOSO: begin
            listo = 1'b1;
            if (inicio) begin
               // Division by zero bypasses the iterative divider entirely.
               if (esDivision && !divisorCero) begin
                  estadoNext = DIVIDE;
               end else begin
                  estadoNext = EJECUTA;
               end
            end
         end
         DIVIDE: begin
            if (contadorReg == '0) begin
               estadoNext = EJECUTA;
            end
         end
         EJECUTA: begin
            seleccion  = opReg;
            estadoNext = ENTREGA;
         end
         ENTREGA: begin
            if (aceptado) begin
               estadoNext = REPOSO;
            end
         end
         default: begin
            estadoNext = REPOSO;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         datoA              <= '0;
         datoB              <= '0;
         opReg              <= 4'b0000;
         cociente           <= '0;
         residuo            <= '0;
         restoReg           <= '0;
         cocienteParcialReg <= '0;
         contadorReg        <= '0;
         resultado          <= '0;
         valido             <= 1'b0;
         error_div          <= 1'b0;
         error_op           <= 1'b0;
      end else begin
         case (estadoReg)
            REPOSO: begin
               if (inicio) begin
                  datoA              <= operandoA;
                  datoB              <= operandoB;
                  opReg              <= operacion;
                  error_div          <= esDivision && divisorCero;
                  error_op           <= 1'b0;
                  restoReg           <= '0;
                  cocienteParcialReg <= operandoA;
                  contadorReg        <= anchoCnt'(ancho - 1);
                  if (esDivision && divisorCero) begin
                     cociente <= '1;
                     residuo  <= operandoA;
                  end
               end
            end
            DIVIDE: begin
               restoReg           <= restoNext;
               cocienteParcialReg <= cocienteNext;
               contadorReg        <= contadorReg - 1'b1;
               // The mux inputs only change once the quotient is complete.
               if (contadorReg == '0) begin
                  cociente <= cocienteNext;
                  residuo  <= restoNext;
               end
            end
            EJECUTA: begin
               resultado <= salidaMux;
               valido    <= 1'b1;
               error_op  <= (opReg >= 4'b1011);
            end
            ENTREGA: begin
               if (aceptado) begin
                  valido <= 1'b0;
               end
            end
            default: begin
               valido <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Result flags
   // ---------------------------------------------------------------
`ifdef BANDERAS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cero     <= 1'b0;
         negativo <= 1'b0;
      end else if (estadoReg == EJECUTA) begin
         cero     <= (salidaMux == '0);
         negativo <= salidaMux[ancho-1];
      end
   end
`else
   assign cero     = 1'b0;
   assign negativo = 1'b0;
`endif

endmodule
